// File: rtl/dmem_responder.sv
// Data-memory target for the CPU load/store port: decodes access width, inserts
// WAIT_CYCLES wait states, commits stores and returns sign/zero-extended load data.
module dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic [2:0]  dm_ctrl,
    output logic [31:0] Data_out,
    output logic        ready,
    output logic        stall,
    output logic        misalign
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_half(input logic [2:0] c);
        return (c == 3'b001) || (c == 3'b010);
    endfunction

    function automatic logic is_byte(input logic [2:0] c);
        return (c == 3'b011) || (c == 3'b100);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] c, input logic [1:0] a);
        logic m;
        if (is_half(c)) begin
            m = a[0];
        end else if (is_byte(c)) begin
            m = 1'b0;
        end else begin
            m = (a != 2'b00);
        end
        return m;
    endfunction

    function automatic logic [3:0] lane_enable(input logic [2:0] c, input logic [1:0] a);
        logic [3:0] be;
        if (is_half(c)) begin
            be = a[1] ? 4'b1100 : 4'b0011;
        end else if (is_byte(c)) begin
            be = 4'b0001 << a;
        end else begin
            be = 4'b1111;
        end
        return be;
    endfunction

    // Store data is replicated across lanes so the byte enables alone pick the target lane.
    function automatic logic [31:0] lane_data(input logic [2:0] c, input logic [31:0] d);
        logic [31:0] r;
        if (is_half(c)) begin
            r = {2{d[15:0]}};
        end else if (is_byte(c)) begin
            r = {4{d[7:0]}};
        end else begin
            r = d;
        end
        return r;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] c, input logic [1:0] a,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (c)
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = {16'd0, h};
            3'b011:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            default: r = w;
        endcase
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [2:0]      ctrl_q, ctrl_d;
    logic            wr_q, wr_d;
    logic            ready_q, ready_d;
    logic            misalign_q, misalign_d;
    logic [31:0]     dout_q, dout_d;
    logic [31:0]     mem_q [DEPTH];

    logic [AW+1:0]   cur_addr_s;
    logic [31:0]     cur_wdata_s;
    logic [2:0]      cur_ctrl_s;
    logic            cur_wr_s;
    logic            cur_mis_s;
    logic [AW-1:0]   idx_s;
    logic [31:0]     rdword_s;
    logic [3:0]      be_s;
    logic [31:0]     wlane_s;
    logic            enter_done_s;
    logic            commit_s;
    logic            unused_addr_s;

    assign unused_addr_s = ^Addr_in[31:AW+2];

    // Completing straight out of IDLE (no wait states) must use the live request.
    always_comb begin
        if (state_q == S_IDLE) begin
            cur_addr_s  = Addr_in[AW+1:0];
            cur_wdata_s = Data_in;
            cur_ctrl_s  = dm_ctrl;
            cur_wr_s    = mem_w;
        end else begin
            cur_addr_s  = addr_q;
            cur_wdata_s = wdata_q;
            cur_ctrl_s  = ctrl_q;
            cur_wr_s    = wr_q;
        end
    end

    assign idx_s     = cur_addr_s[AW+1:2];
    assign rdword_s  = mem_q[idx_s];
    assign cur_mis_s = is_misaligned(cur_ctrl_s, cur_addr_s[1:0]);
    assign be_s      = lane_enable(cur_ctrl_s, cur_addr_s[1:0]);
    assign wlane_s   = lane_data(cur_ctrl_s, cur_wdata_s);

    // Next-state, capture and completion logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ctrl_d       = ctrl_q;
        wr_d         = wr_q;
        ready_d      = 1'b0;
        misalign_d   = misalign_q;
        dout_d       = dout_q;
        enter_done_s = 1'b0;
        commit_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_r || mem_w) begin
                    addr_d     = Addr_in[AW+1:0];
                    wdata_d    = Data_in;
                    ctrl_d     = dm_ctrl;
                    wr_d       = mem_w;
                    misalign_d = 1'b0;
                    cnt_d      = CW'(WAIT_CYCLES);
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d      = S_DONE;
                        enter_done_s = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d      = S_DONE;
                    enter_done_s = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (enter_done_s) begin
            ready_d    = 1'b1;
            misalign_d = cur_mis_s;
            commit_s   = cur_wr_s && !cur_mis_s;
            dout_d     = (cur_wr_s || cur_mis_s) ? 32'd0
                                                 : load_extract(cur_ctrl_s, cur_addr_s[1:0], rdword_s);
        end else begin
            commit_s = 1'b0;
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            ctrl_q     <= 3'd0;
            wr_q       <= 1'b0;
            ready_q    <= 1'b0;
            misalign_q <= 1'b0;
            dout_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ctrl_q     <= ctrl_d;
            wr_q       <= wr_d;
            ready_q    <= ready_d;
            misalign_q <= misalign_d;
            dout_q     <= dout_d;
        end
    end

    // Storage survives reset; a store whose commit edge coincides with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst && commit_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_q[idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
                end
            end
        end
    end

    assign Data_out = dout_q;
    assign ready    = ready_q;
    assign misalign = misalign_q;
    assign stall    = (mem_r | mem_w) & ~ready_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: directed scenarios on WAIT_CYCLES=2 and 0 instances plus a
// randomized run against a byte-array reference model.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r, mem_w, sel;
    logic [31:0] addr, wdata;
    logic [2:0]  ctrl;
    logic [31:0] dout2, dout0;
    logic        rdy2, rdy0, stall2, stall0, mis2, mis0;
    logic [31:0] dout_s;
    logic        ready_s, stall_s, mis_s;
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  mem_m [4096];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .mem_r(mem_r & ~sel), .mem_w(mem_w & ~sel),
        .Addr_in(addr), .Data_in(wdata), .dm_ctrl(ctrl),
        .Data_out(dout2), .ready(rdy2), .stall(stall2), .misalign(mis2));

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .mem_r(mem_r & sel), .mem_w(mem_w & sel),
        .Addr_in(addr), .Data_in(wdata), .dm_ctrl(ctrl),
        .Data_out(dout0), .ready(rdy0), .stall(stall0), .misalign(mis0));

    assign dout_s  = sel ? dout0  : dout2;
    assign ready_s = sel ? rdy0   : rdy2;
    assign stall_s = sel ? stall0 : stall2;
    assign mis_s   = sel ? mis0   : mis2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Little-endian byte-array model of one access; returns expected Data_out and misalign.
    task automatic model_op(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] c, output logic [31:0] ed, output logic em);
        int     sz;
        int     base;
        bit     sgn;
        longint v;
        sz   = (c == 3'd1 || c == 3'd2) ? 2 : ((c == 3'd3 || c == 3'd4) ? 1 : 4);
        sgn  = (c == 3'd1 || c == 3'd3);
        base = int'(a % 32'd4096);
        em   = ((a % sz) != 0);
        ed   = 32'd0;
        if (!em) begin
            if (wr) begin
                for (int i = 0; i < sz; i++) mem_m[base+i] = d[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < sz; i++) v += longint'(mem_m[base+i]) << (8*i);
                if (sgn && v >= (longint'(1) << (8*sz-1))) v -= longint'(1) << (8*sz);
                ed = v[31:0];
            end
        end
    endtask

    // One complete handshake; returns in the IDLE cycle after completion.
    task automatic access(input string tag, input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] c,
                          output logic [31:0] rd, output logic mis, output int lat);
        mem_w = w; mem_r = r; addr = a; wdata = d; ctrl = c; lat = 0;
        #1;
        check({tag, ".stall_req"}, {31'd0, stall_s}, 32'd1);
        do begin
            @(posedge clk); #1; lat++;
        end while (!ready_s && lat < 20);
        rd  = dout_s;
        mis = mis_s;
        check({tag, ".stall_done"}, {31'd0, stall_s}, 32'd0);
        mem_w = 1'b0; mem_r = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic op(input string tag, input logic w, input logic r, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] c,
                      input logic [31:0] exp_d, input logic exp_m);
        logic [31:0] rd;
        logic        mis;
        int          lat;
        access(tag, w, r, a, d, c, rd, mis, lat);
        check({tag, ".data"}, rd, exp_d);
        check({tag, ".misalign"}, {31'd0, mis}, {31'd0, exp_m});
        check({tag, ".latency"}, lat, sel ? 32'd1 : 32'd3);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ed, a, d;
        logic        em, w, r;
        logic [2:0]  c;
        int          pulses;

        rst = 1'b0; sel = 1'b0; mem_r = 1'b0; mem_w = 1'b0;
        addr = 32'd0; wdata = 32'd0; ctrl = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.ready", {31'd0, ready_s}, 32'd0);
        check("reset.misalign", {31'd0, mis_s}, 32'd0);
        check("reset.data", dout_s, 32'd0);
        check("reset.stall", {31'd0, stall_s}, 32'd0);
        rst = 1'b1;

        op("sw10", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 3'd0, 32'd0, 1'b0);
        op("lw10", 1'b0, 1'b1, 32'h10, 32'd0, 3'd0, 32'hDEADBEEF, 1'b0);

        op("sw20", 1'b1, 1'b0, 32'h20, 32'h12345678, 3'd0, 32'd0, 1'b0);
        op("sb22", 1'b1, 1'b0, 32'h22, 32'h00000080, 3'd3, 32'd0, 1'b0);
        op("lw20", 1'b0, 1'b1, 32'h20, 32'd0, 3'd0, 32'h12805678, 1'b0);
        op("lb22", 1'b0, 1'b1, 32'h22, 32'd0, 3'd3, 32'hFFFFFF80, 1'b0);
        op("lbu22", 1'b0, 1'b1, 32'h22, 32'd0, 3'd4, 32'h00000080, 1'b0);

        op("sw30", 1'b1, 1'b0, 32'h30, 32'h00000000, 3'd0, 32'd0, 1'b0);
        op("sh32", 1'b1, 1'b0, 32'h32, 32'hFFFF9ABC, 3'd1, 32'd0, 1'b0);
        op("lh32", 1'b0, 1'b1, 32'h32, 32'd0, 3'd1, 32'hFFFF9ABC, 1'b0);
        op("lhu32", 1'b0, 1'b1, 32'h32, 32'd0, 3'd2, 32'h00009ABC, 1'b0);
        op("lw30", 1'b0, 1'b1, 32'h30, 32'd0, 3'd0, 32'h9ABC0000, 1'b0);

        op("sw40", 1'b1, 1'b0, 32'h40, 32'h01020304, 3'd0, 32'd0, 1'b0);
        op("sw41_mis", 1'b1, 1'b0, 32'h41, 32'h11111111, 3'd0, 32'd0, 1'b1);
        op("lw40_keep", 1'b0, 1'b1, 32'h40, 32'd0, 3'd0, 32'h01020304, 1'b0);
        op("lh43_mis", 1'b0, 1'b1, 32'h43, 32'd0, 3'd1, 32'd0, 1'b1);
        op("ctrl5_word", 1'b0, 1'b1, 32'h40, 32'd0, 3'd5, 32'h01020304, 1'b0);
        op("ctrl7_mis", 1'b0, 1'b1, 32'h42, 32'd0, 3'd7, 32'd0, 1'b1);

        op("sw1004", 1'b1, 1'b0, 32'h1004, 32'hA5A55A5A, 3'd0, 32'd0, 1'b0);
        op("lw0004", 1'b0, 1'b1, 32'h0004, 32'd0, 3'd0, 32'hA5A55A5A, 1'b0);

        // Reset during WAIT drops the pending store and clears the outputs.
        op("sw50_old", 1'b1, 1'b0, 32'h50, 32'h600DF00D, 3'd0, 32'd0, 1'b0);
        op("lw50_pre", 1'b0, 1'b1, 32'h50, 32'd0, 3'd0, 32'h600DF00D, 1'b0);
        mem_w = 1'b1; addr = 32'h50; wdata = 32'hCAFEF00D; ctrl = 3'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; mem_w = 1'b0;
        @(posedge clk); #1;
        check("rstwait.ready", {31'd0, ready_s}, 32'd0);
        check("rstwait.data", dout_s, 32'd0);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ready_s) pulses++;
        end
        check("rstwait.no_pulse", pulses, 32'd0);
        op("lw50_post", 1'b0, 1'b1, 32'h50, 32'd0, 3'd0, 32'h600DF00D, 1'b0);

        // Reset in the DONE cycle clears a set misalign flag.
        mem_r = 1'b1; addr = 32'h43; ctrl = 3'd1;
        pulses = 0;
        do begin
            @(posedge clk); #1; pulses++;
        end while (!ready_s && pulses < 20);
        check("rstdone.mis_before", {31'd0, mis_s}, 32'd1);
        rst = 1'b0; mem_r = 1'b0;
        @(posedge clk); #1;
        check("rstdone.ready", {31'd0, ready_s}, 32'd0);
        check("rstdone.misalign", {31'd0, mis_s}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // WAIT_CYCLES=0 instance.
        sel = 1'b1;
        op("w0_both", 1'b1, 1'b1, 32'h60, 32'h77665544, 3'd0, 32'd0, 1'b0);
        op("w0_lw60", 1'b0, 1'b1, 32'h60, 32'd0, 3'd0, 32'h77665544, 1'b0);
        mem_r = 1'b1; mem_w = 1'b1; addr = 32'h64; wdata = 32'h13572468; ctrl = 3'd0;
        @(posedge clk); #1;
        check("w0_hold.ready1", {31'd0, ready_s}, 32'd1);
        check("w0_hold.data1", dout_s, 32'd0);
        @(posedge clk); #1;
        check("w0_hold.ready_gap", {31'd0, ready_s}, 32'd0);
        check("w0_hold.stall_gap", {31'd0, stall_s}, 32'd1);
        @(posedge clk); #1;
        check("w0_hold.ready2", {31'd0, ready_s}, 32'd1);
        mem_r = 1'b0; mem_w = 1'b0;
        @(posedge clk); #1;
        op("w0_lw64", 1'b0, 1'b1, 32'h64, 32'd0, 3'd0, 32'h13572468, 1'b0);

        // Randomized accesses against the reference model on the WAIT_CYCLES=2 instance.
        sel = 1'b0;
        for (int i = 0; i < 64; i++) begin
            a = 32'h100 + 32'(4*i);
            d = $urandom;
            model_op(1'b1, a, d, 3'd0, ed, em);
            op("rnd_init", 1'b1, 1'b0, a, d, 3'd0, ed, em);
        end
        for (int i = 0; i < 60; i++) begin
            w = 1'($urandom_range(0, 1));
            r = w ? 1'($urandom_range(0, 1)) : 1'b1;
            a = (32'h100 + 32'($urandom_range(0, 255))) | (32'($urandom_range(0, 3)) << 12);
            d = $urandom;
            c = 3'($urandom_range(0, 7));
            model_op(w, a, d, c, ed, em);
            op("rnd", w, r, a, d, c, ed, em);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
